// File: rtl/piso_serial_tx_pkg.sv
// Shared encodings for the PISO serial transmitter: FSM states, line levels
// and counter width helper.
package piso_serial_tx_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Width needed to hold 0..range_n-1, never narrower than one bit.
    function automatic int cnt_width(input int range_n);
        return (range_n <= 1) ? 1 : $clog2(range_n);
    endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Word-source / serial-line bundle for piso_serial_tx; the source side
// uses the master modport, the transmitter the slave modport.
interface piso_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output load,
        output din,
        input  ready,
        input  sout,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  din,
        output ready,
        output sout,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Right-shifting data register for the transmitter; q0 is the next bit to
// leave the line. Synchronous active-low reset.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (!r) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign q0 = q[0];

endmodule

// File: rtl/piso_serial_tx.sv
// Frame transmitter: start(0), WIDTH data bits LSB-first, optional even
// parity (macro PISO_TX_PARITY_EN), stop(1); each bit held CLKS_PER_BIT clocks.
//
//  state     | meaning
//  ST_IDLE   | line at 1, ready for a word
//  ST_START  | start bit on the line
//  ST_DATA   | data bit bit_cnt on the line
//  ST_PARITY | even parity of the accepted word on the line
//  ST_STOP   | stop bit on the line
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic              clk,
    input logic              r,
    piso_serial_tx_if.slave  bus
);
    localparam int TICK_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_width(WIDTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [BIT_W-1:0]  bit_cnt;
    logic              sout_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;
    logic              q0;
    logic              accept;
    logic              bit_end;
    logic              sh_shift;
`ifdef PISO_TX_PARITY_EN
    logic              par_q;
`endif

    assign accept   = bus.load & ready_q;
    assign bit_end  = (tick == TICK_LAST);
    assign sh_shift = bit_end & ((state == ST_START) | (state == ST_DATA));

    // The register is shifted on the START->DATA edge too, so q0 always holds
    // the bit that goes on the line at the next bit boundary.
    piso_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .r     (r),
        .load  (accept),
        .shift (sh_shift),
        .d     (bus.din),
        .q0    (q0)
    );

    always_ff @(posedge clk) begin
        if (!r) begin
            state   <= ST_IDLE;
            sout_q  <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            tick    <= '0;
            bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_START;
                        sout_q  <= START_LVL;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        tick    <= '0;
`ifdef PISO_TX_PARITY_EN
                        par_q   <= ^bus.din;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                        sout_q  <= q0;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        tick <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
                            state   <= ST_PARITY;
                            sout_q  <= par_q;
`else
                            state   <= ST_STOP;
                            sout_q  <= IDLE_LVL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            sout_q  <= q0;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
`ifdef PISO_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        tick   <= '0;
                        state  <= ST_STOP;
                        sout_q <= IDLE_LVL;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        tick    <= '0;
                        state   <= ST_IDLE;
                        sout_q  <= IDLE_LVL;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    sout_q  <= IDLE_LVL;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    tick    <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.sout  = sout_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx (WIDTH=8, CLKS_PER_BIT=4): a queue-of-line-levels
// model checked every cycle, plus hand-computed frame expectations.
module tb_piso_serial_tx;
    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int NB        = 11;
    localparam int FRAME     = 44;
    localparam int REM_AFTER = 28;
`else
    localparam int NB        = 10;
    localparam int FRAME     = 40;
    localparam int REM_AFTER = 24;
`endif

    logic clk = 1'b0;
    logic r   = 1'b0;

    piso_serial_tx_if #(.WIDTH(W)) bus ();

    piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of line levels still to be driven, one entry per clock.
    logic exp_q[$];
    bit   exp_done = 1'b0;
    bit   chk_en   = 1'b0;
    logic popped;

    task automatic push_frame(input logic [W-1:0] w);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c < CPB; c++) exp_q.push_back(bits[k]);
    endtask

    always @(posedge clk) begin
        if (!r) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (exp_q.size() != 0) begin
                popped = exp_q.pop_front();
                if (exp_q.size() == 0) exp_done = 1'b1;
            end else if (bus.load) begin
                push_frame(bus.din);
            end
        end
        chk_en = 1'b1;
    end

    logic exp_busy;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_busy = (exp_q.size() != 0);
            check("sout",  bus.sout,  exp_busy ? exp_q[0] : 1'b1);
            check("busy",  bus.busy,  exp_busy);
            check("ready", bus.ready, !exp_busy);
            check("done",  bus.done,  exp_done);
        end
    end

    bit lit_a5 [NB];
    bit lit_07 [NB];

    task automatic send_capture(input logic [W-1:0] w, input bit lit[NB], input string tag);
        bit cap [NB];
        int busy_cnt;
        int done_cnt;
        @(negedge clk);
        bus.load = 1'b1;
        bus.din  = w;
        @(negedge clk);
        bus.load = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < FRAME + 3; c++) begin
            if (c < FRAME && (c % CPB) == 1) cap[c / CPB] = bus.sout;
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            @(negedge clk);
        end
        for (int b = 0; b < NB; b++)
            check($sformatf("%s_bit%0d", tag, b), 32'(cap[b]), 32'(lit[b]));
        check({tag, "_busy_len"}, busy_cnt, FRAME);
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    int cnt;
    bit seen;

    initial begin
`ifdef PISO_TX_PARITY_EN
        lit_a5 = '{0, 1,0,1,0,0,1,0,1, 0, 1};
        lit_07 = '{0, 1,1,1,0,0,0,0,0, 1, 1};
`else
        lit_a5 = '{0, 1,0,1,0,0,1,0,1, 1};
        lit_07 = '{0, 1,1,1,0,0,0,0,0, 1};
`endif
        bus.load = 1'b0;
        bus.din  = '0;

        // 1: reset, then idle line
        r = 1'b0;
        repeat (2) @(negedge clk);
        r = 1'b1;
        check("rst_sout",  bus.sout,  1);
        check("rst_ready", bus.ready, 1);
        check("rst_busy",  bus.busy,  0);
        check("rst_done",  bus.done,  0);
        repeat (6) @(negedge clk);

        // 2 and 3: literal frames
        send_capture(8'hA5, lit_a5, "t2_a5");
        send_capture(8'h07, lit_07, "t3_07");

        // 4: load mid-frame is ignored
        @(negedge clk);
        bus.load = 1'b1;
        bus.din  = 8'hA5;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (15) @(negedge clk);
        bus.din  = 8'hFF;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.busy) break;
            cnt++;
            @(negedge clk);
        end
        check("t4_remaining_busy", cnt, REM_AFTER);
        repeat (10) @(negedge clk);
        check("t4_no_second_frame", bus.busy, 0);

        // 5: back-to-back with load held
        @(negedge clk);
        bus.load = 1'b1;
        bus.din  = 8'h3C;
        @(negedge clk);
        bus.din  = 8'hC3;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_done_seen", seen, 1);
        @(negedge clk);
        bus.load = 1'b0;
        check("t5_no_gap_sout", bus.sout, 0);
        check("t5_no_gap_busy", bus.busy, 1);
        repeat (FRAME + 4) @(negedge clk);

        // 6: reset during data bit 3, then a fresh frame
        @(negedge clk);
        bus.load = 1'b1;
        bus.din  = 8'h5A;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (17) @(negedge clk);
        check("t6_busy_before", bus.busy, 1);
        r = 1'b0;
        @(negedge clk);
        check("t6_sout",  bus.sout,  1);
        check("t6_ready", bus.ready, 1);
        check("t6_busy",  bus.busy,  0);
        check("t6_done",  bus.done,  0);
        r = 1'b1;
        send_capture(8'hA5, lit_a5, "t6_fresh");

        // random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            r        = ($urandom_range(0, 249) != 0);
            bus.load = ($urandom_range(0, 3) == 0);
            bus.din  = W'($urandom);
        end
        @(negedge clk);
        r        = 1'b1;
        bus.load = 1'b0;
        repeat (FRAME + 10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
